crossbar_wormhole_pipe: RTL and testbench

// P-port router crossbar with per-output wormhole lock and optional output pipeline register.

---
 rtl/crossbar_wormhole_pipe_if.sv | 27 ++
 rtl/crossbar_wormhole_pipe.sv | 113 +++++++++++
 tb/tb_crossbar_wormhole_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/crossbar_wormhole_pipe_if.sv
// Crossbar data/grant bundle: grants, flits and tails in; flits, valids, lock and error flags out.
// Latency and backpressure are set by the attached crossbar; this bundle adds neither.
interface crossbar_wormhole_pipe_if #(
  parameter int P   = 5,
  parameter int P_1 = 4,
  parameter int Fw  = 36
);
  logic [P*P_1-1:0] granted_dest_port_all;
  logic [P*Fw-1:0]  flit_in_all;
  logic [P-1:0]     tail_flg_in_all;
  logic             err_clr;
  logic [P*Fw-1:0]  flit_out_all;
  logic [P-1:0]     flit_out_wr_all;
  logic [P-1:0]     lock_all;
  logic [P-1:0]     err_multi_all;
  logic [P-1:0]     err_intlv_all;

  modport master (
    output granted_dest_port_all, flit_in_all, tail_flg_in_all, err_clr,
    input  flit_out_all, flit_out_wr_all, lock_all, err_multi_all, err_intlv_all
  );

  modport slave (
    input  granted_dest_port_all, flit_in_all, tail_flg_in_all, err_clr,
    output flit_out_all, flit_out_wr_all, lock_all, err_multi_all, err_intlv_all
  );
endinterface

// File: rtl/crossbar_wormhole_pipe.sv
// Router crossbar with per-output wormhole lock; latency 1 cycle (PIPE_EN=1) or 0.
// No backpressure: losing or interleaving requests are dropped and flagged in sticky error bits.
module crossbar_wormhole_pipe #(
  parameter int P            = 5,
  parameter int Fw           = 36,
  parameter int SELF_LOOP_EN = 0,
  parameter int PIPE_EN      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  crossbar_wormhole_pipe_if.slave bus
);
  localparam int P_1 = (SELF_LOOP_EN != 0) ? P : P - 1;
  localparam int OW  = (P > 1) ? $clog2(P) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state [P];
  logic [OW-1:0]   owner [P];
  logic [P-1:0]    req [P];
  logic [P-1:0]    own_oh [P];
  logic [P-1:0]    sel [P];
  logic [OW-1:0]   enc [P];
  logic [Fw-1:0]   mux [P];
  logic [P*Fw-1:0] flit_flat;
  logic [P-1:0]    wr_nxt, tail_sel, multi, intlv, lock;
  logic [P-1:0]    err_multi, err_intlv;

  // Without self-loop, input j's grant vector skips its own port.
  always_comb begin
    for (int o = 0; o < P; o++) req[o] = '0;
    for (int j = 0; j < P; j++) begin
      for (int k = 0; k < P_1; k++) begin
        int d;
        d = (SELF_LOOP_EN != 0 || k < j) ? k : k + 1;
        if (bus.granted_dest_port_all[j*P_1+k]) req[d][j] = 1'b1;
      end
    end
  end

  always_comb begin
    flit_flat = '0;
    for (int o = 0; o < P; o++) begin
      own_oh[o] = P'(1) << owner[o];
      // IDLE picks the lowest requester; BUSY only lets the owner through.
      sel[o]      = (state[o] == BUSY) ? (req[o] & own_oh[o]) : (req[o] & (~req[o] + P'(1)));
      wr_nxt[o]   = |sel[o];
      tail_sel[o] = |(sel[o] & bus.tail_flg_in_all);
      multi[o]    = |(req[o] & (req[o] - P'(1)));
      intlv[o]    = (state[o] == BUSY) && (|(req[o] & ~own_oh[o]));
      lock[o]     = (state[o] == BUSY);
      mux[o]      = '0;
      enc[o]      = '0;
      for (int j = 0; j < P; j++) begin
        mux[o] = mux[o] | ({Fw{sel[o][j]}} & bus.flit_in_all[j*Fw +: Fw]);
        if (sel[o][j]) enc[o] = OW'(j);
      end
      flit_flat[o*Fw +: Fw] = mux[o];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < P; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
      end
      err_multi <= '0;
      err_intlv <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        if (wr_nxt[o]) begin
          if (state[o] == IDLE && !tail_sel[o]) begin
            state[o] <= BUSY;
            owner[o] <= enc[o];
          end else if (state[o] == BUSY && tail_sel[o]) begin
            state[o] <= IDLE;
          end
        end
      end
      // A new error in the clearing cycle survives the clear.
      err_multi <= (err_multi & ~{P{bus.err_clr}}) | multi;
      err_intlv <= (err_intlv & ~{P{bus.err_clr}}) | intlv;
    end
  end

  generate
    if (PIPE_EN != 0) begin : g_pipe
      logic [P*Fw-1:0] flit_q;
      logic [P-1:0]    wr_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          flit_q <= '0;
          wr_q   <= '0;
        end else begin
          wr_q <= wr_nxt;
          for (int o = 0; o < P; o++) begin
            if (wr_nxt[o]) flit_q[o*Fw +: Fw] <= flit_flat[o*Fw +: Fw];
          end
        end
      end
      assign bus.flit_out_all    = flit_q;
      assign bus.flit_out_wr_all = wr_q;
    end else begin : g_comb
      assign bus.flit_out_all    = flit_flat;
      assign bus.flit_out_wr_all = wr_nxt;
    end
  endgenerate

  assign bus.lock_all      = lock;
  assign bus.err_multi_all = err_multi;
  assign bus.err_intlv_all = err_intlv;
endmodule

// File: tb/tb_crossbar_wormhole_pipe.sv
// Directed bench: piped no-self-loop crossbar (a) and combinational self-loop crossbar (b).
module tb_crossbar_wormhole_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  crossbar_wormhole_pipe_if #(.P(5), .P_1(4), .Fw(36)) a ();
  crossbar_wormhole_pipe_if #(.P(5), .P_1(5), .Fw(36)) b ();

  crossbar_wormhole_pipe #(.P(5), .Fw(36), .SELF_LOOP_EN(0), .PIPE_EN(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a));
  crossbar_wormhole_pipe #(.P(5), .Fw(36), .SELF_LOOP_EN(1), .PIPE_EN(0)) dut_b (
    .clk(clk), .reset(reset), .bus(b));

  task automatic clr_in();
    a.granted_dest_port_all = '0; a.flit_in_all = '0; a.tail_flg_in_all = '0; a.err_clr = 1'b0;
    b.granted_dest_port_all = '0; b.flit_in_all = '0; b.tail_flg_in_all = '0; b.err_clr = 1'b0;
  endtask

  // Grant input i to output o on the no-self-loop crossbar.
  task automatic put(input int i, input int o, input logic [35:0] f, input logic t);
    int k;
    k = (o < i) ? o : o - 1;
    a.granted_dest_port_all[i*4+k] = 1'b1;
    a.flit_in_all[i*36 +: 36] = f;
    a.tail_flg_in_all[i] = t;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr_in();
    #12;
    checks++; if (a.flit_out_all !== '0) begin errors++; $display("FAIL rst_flit act=%h exp=0", a.flit_out_all); end
    checks++; if (a.flit_out_wr_all !== 5'h00) begin errors++; $display("FAIL rst_wr act=%h exp=00", a.flit_out_wr_all); end
    checks++; if (a.lock_all !== 5'h00) begin errors++; $display("FAIL rst_lock act=%h exp=00", a.lock_all); end
    checks++; if ({a.err_multi_all, a.err_intlv_all} !== 10'h000) begin errors++; $display("FAIL rst_err act=%h exp=000", {a.err_multi_all, a.err_intlv_all}); end
    checks++; if (b.flit_out_wr_all !== 5'h00) begin errors++; $display("FAIL rst_b_wr act=%h exp=00", b.flit_out_wr_all); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single();
    clr_in(); put(1, 0, 36'h0A5, 1'b1); step();
    checks++; if (a.flit_out_all[0 +: 36] !== 36'h0A5) begin errors++; $display("FAIL single_flit act=%h exp=0a5", a.flit_out_all[0 +: 36]); end
    checks++; if (a.flit_out_wr_all !== 5'h01) begin errors++; $display("FAIL single_wr act=%h exp=01", a.flit_out_wr_all); end
    checks++; if (a.lock_all !== 5'h00) begin errors++; $display("FAIL single_lock act=%h exp=00", a.lock_all); end
    checks++; if ({a.err_multi_all, a.err_intlv_all} !== 10'h000) begin errors++; $display("FAIL single_err act=%h exp=000", {a.err_multi_all, a.err_intlv_all}); end
  endtask

  task automatic test_back_to_back();
    clr_in(); put(3, 0, 36'h03C, 1'b1); step();
    checks++; if (a.flit_out_all[0 +: 36] !== 36'h03C || a.flit_out_wr_all !== 5'h01) begin errors++; $display("FAIL b2b_second act=%h/%h exp=03c/01", a.flit_out_all[0 +: 36], a.flit_out_wr_all); end
    clr_in(); step();
    checks++; if (a.flit_out_wr_all !== 5'h00) begin errors++; $display("FAIL b2b_idle_wr act=%h exp=00", a.flit_out_wr_all); end
    checks++; if (a.flit_out_all[0 +: 36] !== 36'h03C) begin errors++; $display("FAIL b2b_hold act=%h exp=03c", a.flit_out_all[0 +: 36]); end
  endtask

  task automatic test_packet();
    logic [35:0] f [3];
    f[0] = 36'h111; f[1] = 36'h222; f[2] = 36'h333;
    for (int n = 0; n < 3; n++) begin
      clr_in(); put(2, 4, f[n], (n == 2)); step();
      checks++; if (a.flit_out_all[144 +: 36] !== f[n] || a.flit_out_wr_all !== 5'h10) begin errors++; $display("FAIL pkt_flit%0d act=%h/%h exp=%h/10", n, a.flit_out_all[144 +: 36], a.flit_out_wr_all, f[n]); end
      checks++; if (a.lock_all !== ((n == 2) ? 5'h00 : 5'h10)) begin errors++; $display("FAIL pkt_lock%0d act=%h exp=%h", n, a.lock_all, (n == 2) ? 5'h00 : 5'h10); end
    end
  endtask

  task automatic test_intlv();
    clr_in(); put(2, 4, 36'hB01, 1'b0); step();
    clr_in(); put(2, 4, 36'hB02, 1'b0); put(3, 4, 36'hC02, 1'b0); step();
    checks++; if (a.flit_out_all[144 +: 36] !== 36'hB02 || a.flit_out_wr_all !== 5'h10) begin errors++; $display("FAIL intlv_owner act=%h/%h exp=b02/10", a.flit_out_all[144 +: 36], a.flit_out_wr_all); end
    checks++; if (a.err_intlv_all !== 5'h10) begin errors++; $display("FAIL intlv_flag act=%h exp=10", a.err_intlv_all); end
    clr_in(); put(3, 4, 36'hC03, 1'b1); step();
    checks++; if (a.flit_out_wr_all !== 5'h00 || a.lock_all !== 5'h10) begin errors++; $display("FAIL intlv_drop wr/lock act=%h/%h exp=00/10", a.flit_out_wr_all, a.lock_all); end
    checks++; if (a.flit_out_all[144 +: 36] !== 36'hB02) begin errors++; $display("FAIL intlv_hold act=%h exp=b02", a.flit_out_all[144 +: 36]); end
    clr_in(); put(2, 4, 36'hB04, 1'b1); step();
    checks++; if (a.flit_out_all[144 +: 36] !== 36'hB04 || a.lock_all !== 5'h00) begin errors++; $display("FAIL intlv_tail act=%h/%h exp=b04/00", a.flit_out_all[144 +: 36], a.lock_all); end
    clr_in(); a.err_clr = 1'b1; step();
    checks++; if ({a.err_multi_all, a.err_intlv_all} !== 10'h000) begin errors++; $display("FAIL intlv_clr act=%h exp=000", {a.err_multi_all, a.err_intlv_all}); end
  endtask

  task automatic test_multi();
    clr_in(); put(0, 3, 36'h300, 1'b1); put(1, 3, 36'h311, 1'b1); step();
    checks++; if (a.flit_out_all[108 +: 36] !== 36'h300 || a.flit_out_wr_all !== 5'h08) begin errors++; $display("FAIL multi_win act=%h/%h exp=300/08", a.flit_out_all[108 +: 36], a.flit_out_wr_all); end
    checks++; if (a.err_multi_all !== 5'h08 || a.err_intlv_all !== 5'h00) begin errors++; $display("FAIL multi_flag act=%h/%h exp=08/00", a.err_multi_all, a.err_intlv_all); end
    clr_in(); put(0, 3, 36'h302, 1'b1); put(1, 3, 36'h312, 1'b1); a.err_clr = 1'b1; step();
    checks++; if (a.err_multi_all !== 5'h08) begin errors++; $display("FAIL multi_setwins act=%h exp=08", a.err_multi_all); end
    clr_in(); a.err_clr = 1'b1; step();
    checks++; if (a.err_multi_all !== 5'h00) begin errors++; $display("FAIL multi_clr act=%h exp=00", a.err_multi_all); end
  endtask

  task automatic test_reset_mid();
    clr_in(); put(0, 2, 36'h200, 1'b0); step();
    checks++; if (a.lock_all !== 5'h04) begin errors++; $display("FAIL rmid_lock act=%h exp=04", a.lock_all); end
    #2 reset = 1'b0; #1;
    checks++; if (a.flit_out_all !== '0 || a.flit_out_wr_all !== 5'h00 || a.lock_all !== 5'h00) begin errors++; $display("FAIL rmid_async wr/lock act=%h/%h exp=00/00", a.flit_out_wr_all, a.lock_all); end
    clr_in(); @(negedge clk); reset = 1'b1;
    put(1, 2, 36'h2AA, 1'b1); step();
    checks++; if (a.flit_out_all[72 +: 36] !== 36'h2AA || a.flit_out_wr_all !== 5'h04 || a.err_intlv_all !== 5'h00) begin errors++; $display("FAIL rmid_new act=%h/%h/%h exp=2aa/04/00", a.flit_out_all[72 +: 36], a.flit_out_wr_all, a.err_intlv_all); end
  endtask

  task automatic test_comb_selfloop();
    logic [179:0] exp;
    clr_in(); @(negedge clk);
    b.granted_dest_port_all[12] = 1'b1; b.flit_in_all[72 +: 36] = 36'h5A5; b.tail_flg_in_all[2] = 1'b1; #1;
    exp = '0; exp[72 +: 36] = 36'h5A5;
    checks++; if (b.flit_out_all !== exp || b.flit_out_wr_all !== 5'h04) begin errors++; $display("FAIL comb_pass act=%h/%h exp=%h/04", b.flit_out_all, b.flit_out_wr_all, exp); end
    b.tail_flg_in_all[2] = 1'b0; b.flit_in_all[72 +: 36] = 36'h777; step();
    checks++; if (b.lock_all !== 5'h04) begin errors++; $display("FAIL comb_lock act=%h exp=04", b.lock_all); end
    clr_in(); b.granted_dest_port_all[7] = 1'b1; b.flit_in_all[36 +: 36] = 36'h188; b.tail_flg_in_all[1] = 1'b1; #1;
    checks++; if (b.flit_out_all !== '0 || b.flit_out_wr_all !== 5'h00) begin errors++; $display("FAIL comb_drop act=%h/%h exp=0/00", b.flit_out_all, b.flit_out_wr_all); end
    step();
    checks++; if (b.err_intlv_all !== 5'h04) begin errors++; $display("FAIL comb_intlv act=%h exp=04", b.err_intlv_all); end
    clr_in(); b.granted_dest_port_all[12] = 1'b1; b.tail_flg_in_all[2] = 1'b1; step();
    checks++; if (b.lock_all !== 5'h00) begin errors++; $display("FAIL comb_unlock act=%h exp=00", b.lock_all); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_packet();
    test_intlv();
    test_multi();
    test_reset_mid();
    test_comb_selfloop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
